// File: rtl/vend_session_arbiter.sv
// ---------------------------------------------------------------------------
// vend_session_arbiter
//
// Shares one vending core between N customer ports. A port holding req_i is
// granted round-robin, its packed coin sequence is latched and checked, and
// valid payments are fed to the core one coin per cycle until at least 1.5
// units have been inserted. The arbiter then waits a bounded time for the
// core's sell, and reports change, unfed-coin count and status to the
// granted port in a single DONE cycle.
//
// Ports:
//   clk       system clock
//   rstn      asynchronous active-low reset (shared with the core)
//   req_i     per-port request level, looked at only while idle
//   coins_i   per-port coin sequence, 4 slots x 2 bits, slot0 in bits [1:0]
//             (01 = 0.5, 10 = 1.0, 00 = end, 11 = invalid)
//   gnt_o     one-hot pulse in the cycle a request is accepted
//   done_o    one-hot pulse in the cycle a session finishes
//   chg_o     change reported by the core, valid with done_o
//   left_o    latched coins that were not fed, valid with done_o
//   err_o     00 ok, 01 insufficient, 10 invalid code, 11 timeout
//   busy_o    high whenever a session is in progress
//   coin_o    coin presented to the core, 00 outside FEED
//   sell_i    core sell indication
//   change_i  core change, sampled together with sell_i
// ---------------------------------------------------------------------------
module vend_session_arbiter #(
   parameter int N       = 2,
   parameter int TIMEOUT = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   req_i,
   input  logic [8*N-1:0] coins_i,
   output logic [N-1:0]   gnt_o,
   output logic [N-1:0]   done_o,
   output logic [1:0]     chg_o,
   output logic [2:0]     left_o,
   output logic [1:0]     err_o,
   output logic           busy_o,
   output logic [1:0]     coin_o,
   input  logic           sell_i,
   input  logic [1:0]     change_i
);

   localparam int PW = (N > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_WAIT,
      S_DONE
   } state_t;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------

   // Value of one coin slot in half-units.
   function automatic logic [2:0] coin_val(input logic [1:0] c);
      case (c)
         2'b01:   coin_val = 3'd1;
         2'b10:   coin_val = 3'd2;
         default: coin_val = 3'd0;
      endcase
   endfunction

   // Accumulator add that clamps at 7 half-units.
   function automatic logic [2:0] sat_add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      sat_add = (s > 4'd7) ? 3'd7 : s[2:0];
   endfunction

   // (base + off) mod N for a port index.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      logic [PW:0] s;
      s = {1'b0, base} + (PW+1)'(off);
      if (s >= (PW+1)'(N))
         s = s - (PW+1)'(N);
      wrap_add = s[PW-1:0];
   endfunction

   // Number of nonzero slots before the first terminator in the three
   // slots that remain after the coin currently being fed.
   function automatic logic [2:0] count_left(input logic [5:0] s);
      logic       stop;
      logic [2:0] n;
      stop = 1'b0;
      n    = 3'd0;
      for (int i = 0; i < 3; i++) begin
         if (!stop) begin
            if (s[2*i +: 2] == 2'b00)
               stop = 1'b1;
            else
               n = n + 3'd1;
         end
      end
      count_left = n;
   endfunction

   // Status of a freshly latched sequence: an invalid code ahead of the
   // terminator wins over an insufficient total.
   function automatic logic [1:0] check_seq(input logic [7:0] c);
      logic       stop;
      logic       bad;
      logic [3:0] tot;
      stop = 1'b0;
      bad  = 1'b0;
      tot  = 4'd0;
      for (int i = 0; i < 4; i++) begin
         if (!stop) begin
            case (c[2*i +: 2])
               2'b00:   stop = 1'b1;
               2'b11:   begin bad = 1'b1; stop = 1'b1; end
               default: tot = tot + {1'b0, coin_val(c[2*i +: 2])};
            endcase
         end
      end
      if (bad)
         check_seq = 2'b10;
      else if (tot < 4'd3)
         check_seq = 2'b01;
      else
         check_seq = 2'b00;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t        state, state_nxt;
   logic [PW-1:0] rr, rr_nxt;
   logic [PW-1:0] sel, sel_nxt;
   logic [7:0]    sreg, sreg_nxt;
   logic [2:0]    acc, acc_nxt;
   logic [2:0]    left_r, left_nxt;
   logic [1:0]    err_r, err_nxt;
   logic [1:0]    chg_r, chg_nxt;
   logic [3:0]    wcnt, wcnt_nxt;

   // Arbitration results
   logic          found;
   logic [PW-1:0] pick;
   logic [PW-1:0] cand;
   logic [7:0]    sel_coins;
   logic          grant;

   // Round-robin search: first requesting port at or after rr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = wrap_add(rr, i);
         for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (cand == PW'(j))) begin
               found = 1'b1;
               pick  = cand;
            end
         end
      end
   end

   // Coin sequence of the port being picked.
   always_comb begin
      sel_coins = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (pick == PW'(i))
            sel_coins = coins_i[8*i +: 8];
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      sel_nxt   = sel;
      sreg_nxt  = sreg;
      acc_nxt   = acc;
      left_nxt  = left_r;
      err_nxt   = err_r;
      chg_nxt   = chg_r;
      wcnt_nxt  = wcnt;
      coin_o    = 2'b00;
      grant     = 1'b0;

      case (state)
         S_IDLE: begin
            if (found) begin
               grant     = 1'b1;
               sel_nxt   = pick;
               sreg_nxt  = sel_coins;
               acc_nxt   = 3'd0;
               left_nxt  = 3'd0;
               chg_nxt   = 2'b00;
               wcnt_nxt  = 4'd0;
               err_nxt   = check_seq(sel_coins);
               state_nxt = (check_seq(sel_coins) == 2'b00) ? S_FEED : S_DONE;
            end
         end

         S_FEED: begin
            coin_o   = sreg[1:0];
            acc_nxt  = sat_add(acc, coin_val(sreg[1:0]));
            sreg_nxt = {2'b00, sreg[7:2]};
            // Validation guarantees the target is reached before the
            // terminator, so feeding always stops here.
            if (acc_nxt >= 3'd3) begin
               left_nxt = count_left(sreg[7:2]);
               wcnt_nxt = 4'd0;
               if (sell_i) begin
                  chg_nxt   = change_i;
                  err_nxt   = 2'b00;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (sell_i) begin
               chg_nxt   = change_i;
               err_nxt   = 2'b00;
               state_nxt = S_DONE;
            end else if (wcnt == 4'(TIMEOUT - 1)) begin
               chg_nxt   = 2'b00;
               err_nxt   = 2'b11;
               state_nxt = S_DONE;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
            end
         end

         S_DONE: begin
            // The port just served drops to lowest priority.
            rr_nxt    = wrap_add(sel, 1);
            state_nxt = S_IDLE;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // Control registers: cleared by reset, which silently abandons a session.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         rr    <= '0;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
         sel   <= sel_nxt;
      end
   end

   // Session data: only observed through DONE or FEED, which reset leaves.
   always_ff @(posedge clk) begin
      sreg   <= sreg_nxt;
      acc    <= acc_nxt;
      left_r <= left_nxt;
      err_r  <= err_nxt;
      chg_r  <= chg_nxt;
      wcnt   <= wcnt_nxt;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      gnt_o  = '0;
      done_o = '0;
      for (int i = 0; i < N; i++) begin
         // Grant is combinational on req_i, so keep it quiet during reset.
         gnt_o[i]  = grant && rstn && (pick == PW'(i));
         done_o[i] = (state == S_DONE) && (sel == PW'(i));
      end
   end

   assign chg_o  = (state == S_DONE) ? chg_r  : 2'b00;
   assign left_o = (state == S_DONE) ? left_r : 3'd0;
   assign err_o  = (state == S_DONE) ? err_r  : 2'b00;
   assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_vend_session_arbiter.sv
module tb_vend_session_arbiter;

   localparam int N       = 2;
   localparam int TIMEOUT = 4;

   logic           clk;
   logic           rstn;
   logic [N-1:0]   req_i;
   logic [8*N-1:0] coins_i;
   logic [N-1:0]   gnt_o;
   logic [N-1:0]   done_o;
   logic [1:0]     chg_o;
   logic [2:0]     left_o;
   logic [1:0]     err_o;
   logic           busy_o;
   logic [1:0]     coin_o;
   logic           sell_i;
   logic [1:0]     change_i;

   vend_session_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_i    (req_i),
      .coins_i  (coins_i),
      .gnt_o    (gnt_o),
      .done_o   (done_o),
      .chg_o    (chg_o),
      .left_o   (left_o),
      .err_o    (err_o),
      .busy_o   (busy_o),
      .coin_o   (coin_o),
      .sell_i   (sell_i),
      .change_i (change_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] done;
      logic [1:0]   chg;
      logic [2:0]   left;
      logic [1:0]   err;
   } done_t;

   logic [N-1:0] gnt_q  [$];
   logic [1:0]   coin_q [$];
   done_t        done_q [$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_gnt(input logic [N-1:0] g);
      gnt_q.push_back(g);
   endtask

   task automatic exp_coin(input logic [1:0] c, input int times);
      for (int i = 0; i < times; i++) coin_q.push_back(c);
   endtask

   task automatic exp_done(input logic [N-1:0] d, input logic [1:0] chg,
                           input logic [2:0] left, input logic [1:0] err);
      done_t e;
      e.done = d; e.chg = chg; e.left = left; e.err = err;
      done_q.push_back(e);
   endtask

   // Monitor: compares every observed DUT event against the scoreboard.
   always @(negedge clk) begin
      if (rstn) begin
         if (gnt_o != '0) begin
            if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt_o), 32'h0);
            else check("gnt", 32'(gnt_o), 32'(gnt_q.pop_front()));
         end
         if (coin_o != 2'b00) begin
            if (coin_q.size() == 0) check("coin_unexpected", 32'(coin_o), 32'h0);
            else check("coin", 32'(coin_o), 32'(coin_q.pop_front()));
         end
         if (done_o != '0) begin
            if (done_q.size() == 0) begin
               check("done_unexpected", 32'(done_o), 32'h0);
            end else begin
               done_t e;
               e = done_q.pop_front();
               check("done", 32'(done_o), 32'(e.done));
               check("chg",  32'(chg_o),  32'(e.chg));
               check("left", 32'(left_o), 32'(e.left));
               check("err",  32'(err_o),  32'(e.err));
            end
         end
      end
   end

   // One session: raise the request mask for the arbitration cycle, pulse
   // sell in cycle sell_at after the grant (0 = never), and check that
   // done arrives exactly exp_lat cycles after the grant.
   task automatic run_session(input logic [N-1:0] reqm, input int sell_at,
                              input logic [1:0] chg_in, input int exp_lat);
      int cyc;
      bit seen;
      @(posedge clk); #1;
      req_i = reqm;
      @(posedge clk); #1;
      req_i    = '0;
      change_i = chg_in;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         if (done_o != '0) begin
            seen = 1'b1;
         end else begin
            sell_i = (cyc == sell_at);
            @(posedge clk); #1;
            cyc++;
         end
      end
      sell_i = 1'b0;
      if (!seen) check("done_timeout", 32'(cyc), 32'(exp_lat));
      else check("latency", 32'(cyc), 32'(exp_lat));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn     = 1'b0;
      req_i    = '0;
      coins_i  = '0;
      sell_i   = 1'b0;
      change_i = 2'b00;

      // Reset state, including a request held during reset.
      req_i = 2'b01;
      coins_i[7:0] = 8'b0000_1010;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt",  32'(gnt_o),  32'h0);
      check("rst_done", 32'(done_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_coin", 32'(coin_o), 32'h0);
      check("rst_err",  32'(err_o),  32'h0);
      check("rst_out",  32'({chg_o, left_o}), 32'h0);
      req_i = '0;
      rstn  = 1'b1;

      // Three half-coins, sold in the final feed cycle.
      coins_i[7:0] = 8'b0001_0101;
      exp_gnt(2'b01); exp_coin(2'b01, 3); exp_done(2'b01, 2'b00, 3'd0, 2'b00);
      run_session(2'b01, 3, 2'b00, 4);

      // Port 1, two whole coins, change 0.5.
      coins_i[15:8] = 8'b0000_1010;
      exp_gnt(2'b10); exp_coin(2'b10, 2); exp_done(2'b10, 2'b01, 3'd0, 2'b00);
      run_session(2'b10, 2, 2'b01, 3);

      // Trailing whole coin is never fed.
      coins_i[7:0] = 8'b1001_0101;
      exp_gnt(2'b01); exp_coin(2'b01, 3); exp_done(2'b01, 2'b00, 3'd1, 2'b00);
      run_session(2'b01, 3, 2'b00, 4);

      // Insufficient payment, then invalid code.
      coins_i[7:0] = 8'b0000_0101;
      exp_gnt(2'b01); exp_done(2'b01, 2'b00, 3'd0, 2'b01);
      run_session(2'b01, 0, 2'b00, 1);
      coins_i[7:0] = 8'b0000_1101;
      exp_gnt(2'b01); exp_done(2'b01, 2'b00, 3'd0, 2'b10);
      run_session(2'b01, 0, 2'b00, 1);

      // Port 1, sell arrives during WAIT (second WAIT cycle), change 1.5.
      coins_i[15:8] = 8'b0000_0110;
      exp_gnt(2'b10); exp_coin(2'b10, 1); exp_coin(2'b01, 1);
      exp_done(2'b10, 2'b11, 3'd0, 2'b00);
      run_session(2'b10, 4, 2'b11, 5);

      // Core never sells: timeout after TIMEOUT WAIT cycles, change forced 0.
      coins_i[7:0] = 8'b0001_0101;
      exp_gnt(2'b01); exp_coin(2'b01, 3); exp_done(2'b01, 2'b00, 3'd0, 2'b11);
      run_session(2'b01, 0, 2'b11, 3 + TIMEOUT + 1);

      // Reset in the first FEED cycle of a port-1 session (rr points at 1).
      coins_i[15:8] = 8'b0001_0101;
      exp_gnt(2'b10);
      @(posedge clk); #1;
      req_i = 2'b10;
      @(posedge clk); #1;
      req_i = '0;
      check("feed_busy", 32'(busy_o), 32'h1);
      rstn = 1'b0;
      #1;
      check("abort_busy", 32'(busy_o), 32'h0);
      check("abort_coin", 32'(coin_o), 32'h0);
      check("abort_done", 32'(done_o), 32'h0);
      check("abort_out",  32'({chg_o, left_o, err_o}), 32'h0);
      coins_i = {8'b0000_1010, 8'b0000_1010};
      @(posedge clk); #1;
      rstn = 1'b1;
      exp_gnt(2'b01); exp_coin(2'b10, 2); exp_done(2'b01, 2'b10, 3'd0, 2'b00);
      run_session(2'b11, 2, 2'b10, 3);

      // Both ports requesting continuously from reset; sell held high.
      for (int s = 0; s < 4; s++) begin
         exp_gnt((s % 2 == 0) ? 2'b01 : 2'b10);
         exp_coin(2'b10, 2);
         exp_done((s % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 3'd0, 2'b00);
      end
      rstn     = 1'b0;
      req_i    = 2'b11;
      sell_i   = 1'b1;
      change_i = 2'b00;
      @(posedge clk); #1;
      check("rst2_gnt", 32'(gnt_o), 32'h0);
      rstn = 1'b1;
      for (int c = 0; c < 16; c++) begin
         check("rr_busy", 32'(busy_o), 32'((c % 4) != 0));
         if (c == 15) begin
            req_i  = '0;
            sell_i = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("final_idle", 32'(busy_o), 32'h0);

      repeat (3) @(posedge clk);
      check("gnt_q_left",  32'(gnt_q.size()),  32'h0);
      check("coin_q_left", 32'(coin_q.size()), 32'h0);
      check("done_q_left", 32'(done_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
